tick_scheduler: RTL

Rate controller for the board time base: produces single-cycle clock-enable ticks instead of derived clocks. A free-running scan tick drives the display multiplexer. A gated, rate-selectable event tick drives counters and state machines. The block sequences run, stop, single-step and glitch-free fast/slow rate switching, replacing the mux-selected toggle clocks used in earlier labs.

---
 rtl/tick_scheduler.sv | 108 ++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Board time base: a free-running scan tick and a gated, rate-selectable event tick,
// both delivered as single-cycle clock enables.
module tick_scheduler #(
  parameter int unsigned FAST_DIV = 200000,
  parameter int unsigned SLOW_DIV = 30000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       rate_sel,
  output logic       tick_scan,
  output logic       tick_evt,
  output logic       rate_act,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2,
    STEP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(SLOW_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] scnt;
  logic [CNT_W-1:0] ecnt, ecnt_d, ecnt_next;
  logic             rate_d, tick_d, tc;

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt      <= '0;
      tick_scan <= 1'b0;
    end else begin
      tick_scan <= (scnt == FAST_TC);
      scnt      <= (scnt == FAST_TC) ? '0 : scnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ecnt     <= '0;
      rate_act <= 1'b0;
      tick_evt <= 1'b0;
    end else begin
      state_q  <= state_d;
      ecnt     <= ecnt_d;
      rate_act <= rate_d;
      tick_evt <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ecnt_d    = ecnt;
    rate_d    = rate_act;
    tick_d    = 1'b0;
    tc        = (ecnt == (rate_act ? FAST_TC : SLOW_TC));
    ecnt_next = tc ? '0 : ecnt + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        ecnt_d = '0;
        rate_d = rate_sel;
        if (run)       state_d = RUN;
        else if (step) state_d = STEP;
      end
      RUN: begin
        ecnt_d = ecnt_next;
        tick_d = tc;
        if (!run) begin
          state_d = IDLE;
          ecnt_d  = '0;
        end else if (rate_sel != rate_act) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        // Old rate finishes its period; the new rate takes effect on the boundary tick.
        ecnt_d = ecnt_next;
        tick_d = tc;
        if (!run) begin
          state_d = IDLE;
          ecnt_d  = '0;
        end else if (tc) begin
          rate_d  = rate_sel;
          state_d = RUN;
        end else if (rate_sel == rate_act) begin
          state_d = RUN;
        end
      end
      STEP: begin
        ecnt_d = ecnt_next;
        tick_d = tc;
        if (run)     state_d = RUN;
        else if (tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
